// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-road traffic phase scheduler with pedestrian walk phase.
// Optional flashing-yellow override is enabled by defining TL_FLASH_EN.
module traffic_phase_scheduler #(
    parameter int CW        = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       ped_req,
`ifdef TL_FLASH_EN
    input  logic       flash,
`endif
    output logic [1:0] Alight,
    output logic [1:0] Blight,
    output logic       walk,
    output logic       ped_pend
);

    localparam logic [2:0] ST_AG  = 3'd0;
    localparam logic [2:0] ST_AY  = 3'd1;
    localparam logic [2:0] ST_ARB = 3'd2;
    localparam logic [2:0] ST_BG  = 3'd3;
    localparam logic [2:0] ST_BY  = 3'd4;
    localparam logic [2:0] ST_ARA = 3'd5;
    localparam logic [2:0] ST_PW  = 3'd6;
`ifdef TL_FLASH_EN
    localparam logic [2:0] ST_FL  = 3'd7;
`endif

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] WALK_M1 = CW'(WALK_T - 1);
    localparam logic [CW-1:0] TMR_MAX = {CW{1'b1}};

    logic [2:0]    state_r;
    logic [2:0]    base_nx_s;
    logic [2:0]    state_nx_s;
    logic [CW-1:0] timer_r;
    logic          last_g_r;
    logic          ped_pend_r;
    logic          entering_s;
    logic          min_ok_s;
    logic          gmax_exp_s;
    logic          yel_exp_s;
    logic          ar_exp_s;
    logic          walk_exp_s;

    assign min_ok_s   = tick && (timer_r >= GMIN_M1);
    assign gmax_exp_s = tick && (timer_r == GMAX_M1);
    assign yel_exp_s  = tick && (timer_r == YEL_M1);
    assign ar_exp_s   = tick && (timer_r == AR_M1);
    assign walk_exp_s = tick && (timer_r == WALK_M1);

    // Phase sequencing without the flash override
    always_comb begin
        base_nx_s = state_r;
        case (state_r)
            ST_AG: begin
                if ((min_ok_s && (b_req || ped_pend_r)) || gmax_exp_s) base_nx_s = ST_AY;
                else base_nx_s = ST_AG;
            end
            ST_BG: begin
                if ((min_ok_s && (a_req || ped_pend_r)) || gmax_exp_s) base_nx_s = ST_BY;
                else base_nx_s = ST_BG;
            end
            ST_AY: begin
                if (yel_exp_s) base_nx_s = ST_ARB;
                else base_nx_s = ST_AY;
            end
            ST_BY: begin
                if (yel_exp_s) base_nx_s = ST_ARA;
                else base_nx_s = ST_BY;
            end
            ST_ARB: begin
                if (ar_exp_s) base_nx_s = ped_pend_r ? ST_PW : ST_BG;
                else base_nx_s = ST_ARB;
            end
            ST_ARA: begin
                if (ar_exp_s) base_nx_s = ped_pend_r ? ST_PW : ST_AG;
                else base_nx_s = ST_ARA;
            end
            ST_PW: begin
                if (walk_exp_s) base_nx_s = last_g_r ? ST_AG : ST_BG;
                else base_nx_s = ST_PW;
            end
`ifdef TL_FLASH_EN
            ST_FL: base_nx_s = ST_ARA;
`endif
            default: base_nx_s = ST_AG;
        endcase
    end

`ifdef TL_FLASH_EN
    assign state_nx_s = flash ? ST_FL : base_nx_s;
`else
    assign state_nx_s = base_nx_s;
`endif

    assign entering_s = (state_nx_s != state_r);

    // State register and per-state tick timer (saturating, cleared on change)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_AG;
            timer_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (entering_s) timer_r <= {CW{1'b0}};
            else if (tick && (timer_r != TMR_MAX)) timer_r <= timer_r + {{(CW-1){1'b0}}, 1'b1};
            else timer_r <= timer_r;
        end
    end

    // Remembers which road was green last so the walk phase hands over fairly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_g_r <= 1'b0;
        end else if (entering_s && (state_nx_s == ST_AG)) begin
            last_g_r <= 1'b0;
        end else if (entering_s && (state_nx_s == ST_BG)) begin
            last_g_r <= 1'b1;
`ifdef TL_FLASH_EN
        end else if ((state_r == ST_FL) && entering_s) begin
            last_g_r <= 1'b1;
`endif
        end else begin
            last_g_r <= last_g_r;
        end
    end

    // Pedestrian request latch; a press on the edge entering WALK is absorbed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend_r <= 1'b0;
        end else if (entering_s && (state_nx_s == ST_PW)) begin
            ped_pend_r <= 1'b0;
        end else if ((state_r != ST_PW) && ped_req) begin
            ped_pend_r <= 1'b1;
        end else begin
            ped_pend_r <= ped_pend_r;
        end
    end

`ifdef TL_FLASH_EN
    logic flash_ph_r;

    // Flash phase: 0 shows yellow, 1 shows red; restarts on every entry to FL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_ph_r <= 1'b0;
        end else if (entering_s && (state_nx_s == ST_FL)) begin
            flash_ph_r <= 1'b0;
        end else if ((state_r == ST_FL) && tick) begin
            flash_ph_r <= ~flash_ph_r;
        end else begin
            flash_ph_r <= flash_ph_r;
        end
    end
`endif

    // Lamp decode from registered state only; unknown encodings show all-red
    always_comb begin
        Alight = LAMP_R;
        Blight = LAMP_R;
        walk   = 1'b0;
        case (state_r)
            ST_AG: begin
                Alight = LAMP_G;
                Blight = LAMP_R;
            end
            ST_AY: begin
                Alight = LAMP_Y;
                Blight = LAMP_R;
            end
            ST_BG: begin
                Alight = LAMP_R;
                Blight = LAMP_G;
            end
            ST_BY: begin
                Alight = LAMP_R;
                Blight = LAMP_Y;
            end
            ST_PW: begin
                walk = 1'b1;
            end
`ifdef TL_FLASH_EN
            ST_FL: begin
                Alight = flash_ph_r ? LAMP_R : LAMP_Y;
                Blight = flash_ph_r ? LAMP_R : LAMP_Y;
            end
`endif
            default: begin
                Alight = LAMP_R;
                Blight = LAMP_R;
                walk   = 1'b0;
            end
        endcase
    end

    assign ped_pend = ped_pend_r;

endmodule
